// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and the
// registered output bundle decoded from the state being entered.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    S_WAIT_LOCK   = 2'd0,
    S_PERIPH_HOLD = 2'd1,
    S_CPU_HOLD    = 2'd2,
    S_RUN         = 2'd3
  } rs_state_e;

  // Code 2'b11 is reserved and never produced.
  typedef enum logic [1:0] {
    RST_CAUSE_EXT      = 2'b00,
    RST_CAUSE_LOCKLOSS = 2'b01,
    RST_CAUSE_SW       = 2'b10
  } rst_cause_e;

  typedef struct packed {
    logic periph_resetn;
    logic cpu_resetn;
    logic sys_ready;
  } rst_outs_t;

  // Output levels for a given state; applied on the edge that enters it so the
  // outputs change together with the state register.
  function automatic rst_outs_t outs_for(input rs_state_e s);
    rst_outs_t o;
    o = '0;
    case (s)
      S_CPU_HOLD: o.periph_resetn = 1'b1;
      S_RUN:      o = '{periph_resetn: 1'b1, cpu_resetn: 1'b1, sys_ready: 1'b1};
      default:    o = '0;
    endcase
    return o;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_ff.sv
// Generic multi-flop synchronizer with asynchronous clear to RST_VAL.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its neighbour; blocking '=' would collapse the chain.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for the PLL clock domain: peripherals first, then the
// core. Lock loss or a software request re-enters the sequence; cause is latched.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PERIPH_HOLD_CYCLES = 16,
  parameter int CPU_DELAY_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       periph_resetn,
  output logic       cpu_resetn,
  output logic       sys_ready,
  output logic [1:0] rst_cause
);

  localparam int CNT_W = $clog2(max3(LOCK_STABLE_CYCLES, PERIPH_HOLD_CYCLES,
                                     CPU_DELAY_CYCLES) + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DELAY_CYCLES - 1);

  logic rst_n_i;
  logic locked_s;

  rs_state_e        state;
  logic [CNT_W-1:0] cnt;
  rst_outs_t        outs;
  rst_cause_e       cause;

  // NOTE: the board reset asserts asynchronously but releases only after the
  // chain fills with ones, so no flop sees reset removal near a clock edge.
  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_rst_sync (
    .clk   (clk),
    .clr_n (resetn),
    .d     (1'b1),
    .q     (rst_n_i)
  );

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .clr_n (rst_n_i),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_WAIT_LOCK;
      cnt   <= '0;
      outs  <= outs_for(S_WAIT_LOCK);
      cause <= RST_CAUSE_EXT;
    end else if (state != S_WAIT_LOCK && !locked_s) begin
      // Lock loss overrides everything, including a same-cycle soft request.
      state <= S_WAIT_LOCK;
      cnt   <= '0;
      outs  <= outs_for(S_WAIT_LOCK);
      cause <= RST_CAUSE_LOCKLOSS;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          if (!locked_s) begin
            cnt <= '0;
          end else if (cnt == LOCK_LAST) begin
            state <= S_PERIPH_HOLD;
            cnt   <= '0;
            outs  <= outs_for(S_PERIPH_HOLD);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PERIPH_HOLD: begin
          if (cnt == PERIPH_LAST) begin
            state <= S_CPU_HOLD;
            cnt   <= '0;
            outs  <= outs_for(S_CPU_HOLD);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_CPU_HOLD: begin
          if (cnt == CPU_LAST) begin
            state <= S_RUN;
            cnt   <= '0;
            outs  <= outs_for(S_RUN);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          // A software reset skips the lock-stability wait: lock is known good.
          if (soft_rst_req) begin
            state <= S_PERIPH_HOLD;
            cnt   <= '0;
            outs  <= outs_for(S_PERIPH_HOLD);
            cause <= RST_CAUSE_SW;
          end
        end

        default: begin
          state <= S_WAIT_LOCK;
          cnt   <= '0;
          outs  <= outs_for(S_WAIT_LOCK);
        end
      endcase
    end
  end

  assign periph_resetn = outs.periph_resetn;
  assign cpu_resetn    = outs.cpu_resetn;
  assign sys_ready     = outs.sys_ready;
  assign rst_cause     = cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios followed by
// randomized lock/soft/reset activity against a sequence-position model.
module tb_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LS   = 8;
  localparam int PH   = 4;
  localparam int CD   = 4;
  localparam int TOT  = LS + PH + CD;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       periph_resetn;
  logic       cpu_resetn;
  logic       sys_ready;
  logic [1:0] rst_cause;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: pos counts unbroken locked edges into the release sequence
  // (pos>=LS: lock stable, >=LS+PH: periph released, >=TOT: core released).
  int          pos;
  logic [1:0]  cause_m;
  logic [SYNC-1:0] lp;
  logic [SYNC-1:0] rp;

  reset_sequencer #(
    .SYNC_STAGES        (SYNC),
    .LOCK_STABLE_CYCLES (LS),
    .PERIPH_HOLD_CYCLES (PH),
    .CPU_DELAY_CYCLES   (CD)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pll_locked    (pll_locked),
    .soft_rst_req  (soft_rst_req),
    .periph_resetn (periph_resetn),
    .cpu_resetn    (cpu_resetn),
    .sys_ready     (sys_ready),
    .rst_cause     (rst_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] expected_outs();
    logic p, c;
    p = (pos >= LS + PH);
    c = (pos >= TOT);
    return {p, c, c, cause_m};
  endfunction

  task automatic check_all(input string tag);
    check(tag, {3'b0, periph_resetn, cpu_resetn, sys_ready, rst_cause},
          {3'b0, expected_outs()});
  endtask

  task automatic model_edge();
    if (rp[SYNC-1]) begin
      if (!lp[SYNC-1]) begin
        if (pos >= LS) cause_m = 2'b01;
        pos = 0;
      end else if (soft_rst_req && pos >= TOT) begin
        pos     = LS;
        cause_m = 2'b10;
      end else if (pos < TOT) begin
        pos++;
      end
      lp = {lp[SYNC-2:0], pll_locked};
    end
    rp = resetn ? {rp[SYNC-2:0], 1'b1} : '0;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic assert_reset(input string tag);
    resetn  = 1'b0;
    rp      = '0;
    lp      = '0;
    pos     = 0;
    cause_m = 2'b00;
    #1;
    check(tag, {3'b0, periph_resetn, cpu_resetn, sys_ready, rst_cause}, 8'h00);
  endtask

  task automatic run_until_pos(input int target, input string tag);
    for (int i = 0; i < 200 && pos != target; i++) cycle(tag);
    check({tag, "_reached"}, 8'(pos == target), 8'h01);
  endtask

  task automatic soft_pulse(input string tag);
    soft_rst_req = 1'b1;
    cycle(tag);
    soft_rst_req = 1'b0;
  endtask

  initial begin
    resetn       = 1'b0;
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
    pos          = 0;
    cause_m      = 2'b00;
    lp           = '0;
    rp           = '0;
    #1;
    check("reset_state", {3'b0, periph_resetn, cpu_resetn, sys_ready, rst_cause}, 8'h00);

    // 1: power-up
    cycles(5, "por_hold");
    resetn = 1'b1;
    cycles(5, "por_release");
    pll_locked = 1'b1;
    cycles(30, "power_up");
    check("power_up_ready", {6'b0, sys_ready, cpu_resetn}, 8'h03);
    check("power_up_cause", {6'b0, rst_cause}, 8'h00);

    // 3: lock loss in S_RUN, observed within SYNC+1 edges
    pll_locked = 1'b0;
    cycles(SYNC + 1, "lock_loss");
    check("lock_loss_periph", {7'b0, periph_resetn}, 8'h00);
    check("lock_loss_cause", {6'b0, rst_cause}, 8'h01);

    // 2: lock chatter restarts the stability count
    pll_locked = 1'b1;
    cycles(5, "chatter_hi");
    pll_locked = 1'b0;
    cycle("chatter_lo");
    pll_locked = 1'b1;
    cycles(LS + 2, "chatter_relock");
    check("chatter_no_release", {7'b0, periph_resetn}, 8'h00);
    cycles(TOT, "relock_seq");
    check("relock_ready", {7'b0, sys_ready}, 8'h01);

    // 4: software reset from S_RUN
    soft_pulse("soft_edge");
    check("soft_resets_low", {6'b0, periph_resetn, cpu_resetn}, 8'h00);
    check("soft_cause", {6'b0, rst_cause}, 8'h02);
    cycles(PH - 1, "soft_periph_wait");
    check("soft_periph_held", {7'b0, periph_resetn}, 8'h00);
    cycle("soft_periph_up");
    check("soft_periph_rise", {7'b0, periph_resetn}, 8'h01);
    cycles(CD, "soft_cpu");
    check("soft_cpu_rise", {7'b0, cpu_resetn}, 8'h01);

    // 5a: soft request on the edge where locked_s first reads 0
    pll_locked = 1'b0;
    cycles(SYNC, "soft_vs_loss_pre");
    soft_pulse("soft_vs_loss");
    check("soft_vs_loss_cause", {6'b0, rst_cause}, 8'h01);

    // 5b: soft request in S_CPU_HOLD is ignored
    pll_locked = 1'b1;
    run_until_pos(LS + PH + 1, "to_cpu_hold");
    soft_pulse("soft_in_cpu_hold");
    check("soft_ignored_cause", {6'b0, rst_cause}, 8'h01);
    run_until_pos(TOT, "to_run");

    // 6: board reset asserted mid-S_CPU_HOLD
    soft_pulse("soft_again");
    run_until_pos(LS + PH + 2, "to_cpu_hold2");
    assert_reset("reset_mid_cpu_hold");
    cycles(3, "reset_held");
    resetn = 1'b1;
    cycles(TOT + 6, "reset_restart");
    check("restart_ready", {6'b0, sys_ready, rst_cause}, 8'h04);

    // randomized activity
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
      soft_rst_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 249) == 0) begin
        assert_reset("rand_reset");
        cycle("rand_reset_hold");
        resetn = 1'b1;
      end
      cycle("random");
    end
    soft_rst_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
